// File: rtl/fetch_pc_unit_if.sv
// Fetch-side signal bundle for fetch_pc_unit: memory address, pre-decode info,
// redirect/training inputs and the registered fetch packet towards decode.
interface fetch_pc_unit_if;
  logic [31:0]      pc_o;
  logic [1:0]       branch_en_i;
  logic [1:0][31:0] imm_i;
  logic             stall_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic             upd_en_i;
  logic [31:0]      upd_pc_i;
  logic             upd_taken_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      out_pc_o;
  logic [1:0]       out_slot_valid_o;
  logic             out_pred_taken_o;
  logic [31:0]      out_pred_target_o;

  // The fetch unit itself.
  modport master (
    output pc_o, out_valid_o, out_pc_o, out_slot_valid_o, out_pred_taken_o, out_pred_target_o,
    input  branch_en_i, imm_i, stall_i, redirect_i, redirect_pc_i,
    input  upd_en_i, upd_pc_i, upd_taken_i, out_ready_i
  );

  // Memory / pre-decoder / execute / decode side.
  modport slave (
    input  pc_o, out_valid_o, out_pc_o, out_slot_valid_o, out_pred_taken_o, out_pred_target_o,
    output branch_en_i, imm_i, stall_i, redirect_i, redirect_pc_i,
    output upd_en_i, upd_pc_i, upd_taken_i, out_ready_i
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Two-slot fetch PC generator with branch prediction and a registered fetch packet.
// Define FETCH_BHT_EN for a 2-bit counter BHT; otherwise static backward-taken prediction.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input logic             clk,
  input logic             rst,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] out_pc_q;
  logic [1:0]  slot_q;
  logic        taken_q;
  logic [31:0] target_q;

  logic [31:0] slot_pc [2];
  logic [1:0]  pred;
  logic [1:0]  nxt_slot;
  logic        nxt_taken;
  logic [31:0] nxt_target;
  logic        capture;

  assign slot_pc[0] = pc_q;
  assign slot_pc[1] = pc_q + 32'd4;

`ifdef FETCH_BHT_EN
  localparam int unsigned IdxW = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [IdxW-1:0] upd_idx;
  logic            unused_upd_pc;

  assign upd_idx       = bus.upd_pc_i[2 +: IdxW];
  assign unused_upd_pc = ^bus.upd_pc_i;

  // Lookups read the registered table, so a same-cycle update is not visible yet.
  always_comb begin
    pred = 2'b00;
    for (int i = 0; i < 2; i++) begin
      pred[i] = bus.branch_en_i[i] & bht_q[slot_pc[i][2 +: IdxW]][1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (bus.upd_en_i) begin
      if (bus.upd_taken_i) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end
`else
  logic unused_static;

  // Backward branches (negative offset) are predicted taken.
  always_comb begin
    pred = 2'b00;
    for (int i = 0; i < 2; i++) begin
      pred[i] = bus.branch_en_i[i] & bus.imm_i[i][31];
    end
  end

  assign unused_static = ^{bus.upd_en_i, bus.upd_pc_i, bus.upd_taken_i, 1'(BHT_ENTRIES)};
`endif

  // The earliest predicted-taken slot ends the packet; otherwise fall through by 8.
  always_comb begin
    nxt_slot   = 2'b11;
    nxt_taken  = 1'b0;
    nxt_target = pc_q + 32'd8;
    if (pred[0]) begin
      nxt_slot   = 2'b01;
      nxt_taken  = 1'b1;
      nxt_target = slot_pc[0] + bus.imm_i[0];
    end else if (pred[1]) begin
      nxt_taken  = 1'b1;
      nxt_target = slot_pc[1] + bus.imm_i[1];
    end
  end

  assign capture = (state_q == StRun) && !bus.stall_i && !bus.redirect_i &&
                   (!valid_q || bus.out_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      out_pc_q <= 32'h0;
      slot_q   <= 2'b00;
      taken_q  <= 1'b0;
      target_q <= 32'h0;
    end else if (bus.redirect_i) begin
      state_q <= StFlush;
      pc_q    <= bus.redirect_pc_i;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot, StFlush: begin
          state_q <= StRun;
          if (bus.out_ready_i) valid_q <= 1'b0;
        end
        StRun: begin
          if (capture) begin
            valid_q  <= 1'b1;
            out_pc_q <= pc_q;
            slot_q   <= nxt_slot;
            taken_q  <= nxt_taken;
            target_q <= nxt_target;
            pc_q     <= nxt_target;
          end else if (bus.out_ready_i) begin
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign bus.pc_o              = pc_q;
  assign bus.out_valid_o       = valid_q;
  assign bus.out_pc_o          = out_pc_q;
  assign bus.out_slot_valid_o  = slot_q;
  assign bus.out_pred_taken_o  = taken_q;
  assign bus.out_pred_target_o = target_q;

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
- REQ-001: Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
- REQ-002: Parameter BHT_ENTRIES, default 16, power of two; counter-table depth when FETCH_BHT_EN is defined.
- REQ-003: clk  in  1  single clock; all state updates on rising edge.
- REQ-004: rst  in  1  reset, synchronous, active-high.
- REQ-005: pc_o  out  32  current fetch address to instruction memory: slot0 = pc_o, slot1 = pc_o+4.
- REQ-006: branch_en_i  in  2  per-slot conditional-branch flag from the fetch pre-decoder, same cycle as pc_o.
- REQ-007: imm_i  in  2x32  per-slot sign-extended B-type offset from the pre-decoder.
- REQ-008: stall_i  in  1  hold fetch; no packet captured, PC held.
- REQ-009: redirect_i  in  1  mispredict/exception redirect from execute; redirect_pc_i  in  32  new fetch address.
- REQ-010: upd_en_i  in  1, upd_pc_i  in  32, upd_taken_i  in  1  resolved-branch training port.
- REQ-011: out_valid_o  out  1, out_ready_i  in  1  fetch-packet handshake to decode.
- REQ-012: out_pc_o  out  32, out_slot_valid_o  out  2, out_pred_taken_o  out  1, out_pred_target_o  out  32  registered fetch packet.

Function
- REQ-013: FSM states BOOT, RUN, FLUSH; BOOT->RUN unconditionally after one cycle; FLUSH->RUN after one cycle.
- REQ-014: Capture when state==RUN, !stall_i, !redirect_i and (!out_valid_o or out_ready_i); capture loads packet registers, sets out_valid_o=1, and loads pc_o with next_pc.
- REQ-015: out_valid_o cleared when out_ready_i=1 and no capture that cycle; packet registers otherwise held stable while out_valid_o=1 and out_ready_i=0.
- REQ-016: Slot predict-taken p[i] = branch_en_i[i] and predictor decision (REQ-026/027).
- REQ-017: p[0]=1: out_slot_valid_o=2'b01, target=pc_o+imm_i[0], next_pc=target.
- REQ-018: p[0]=0, p[1]=1: out_slot_valid_o=2'b11, target=pc_o+4+imm_i[1], next_pc=target.
- REQ-019: neither taken: out_slot_valid_o=2'b11, out_pred_taken_o=0, out_pred_target_o=pc_o+8, next_pc=pc_o+8.
- REQ-020: All address sums modulo 2^32; wrap from 32'hFFFF_FFF8+8 gives 32'h0.
- REQ-021: redirect_i=1: highest priority, overrides stall_i and handshake; next cycle pc_o=redirect_pc_i, out_valid_o=0, state=FLUSH.
- REQ-022: Redirect while in FLUSH or BOOT: pc_o reloaded, state=FLUSH.
- REQ-023: No capture in BOOT or FLUSH; pc_o held.
- REQ-024: Latency: pc_o to packet on outputs = 1 cycle.

Reset
- REQ-025: rst=1 at a clock edge, regardless of state or handshake: pc_o=RESET_PC, out_valid_o=0, out_pc_o=0, out_slot_valid_o=0, out_pred_taken_o=0, out_pred_target_o=0, state=BOOT, all BHT counters=2'b01; rst dominates redirect_i and upd_en_i.

Configuration
- REQ-026: Macro FETCH_BHT_EN defined: BHT of BHT_ENTRIES 2-bit saturating counters indexed pc[2+:log2(BHT_ENTRIES)] of each slot address; taken = counter[1]; upd_en_i increments (taken) or decrements (not taken) entry at upd_pc_i, saturating at 3 and 0; same-cycle lookup of the updated index returns the pre-update value.
- REQ-027: FETCH_BHT_EN undefined: static backward-taken/forward-not-taken, decision = imm_i[i][31]; no counter storage; upd_* ports present and ignored.

Verification
- REQ-028: rst 1 cycle, then no branches, out_ready_i=1 -> pc_o 0, 0(BOOT), 8, 16; packets out_pc_o 0 then 8, slot_valid 2'b11.
- REQ-029: pc_o=32'h100, branch_en_i=2'b01, imm_i[0]=32'hFFFF_FFF0 (static) -> packet slot_valid 2'b01, pred_taken 1, target 32'hF0; next pc_o=32'hF0.
- REQ-030: pc_o=32'h200, branch_en_i=2'b10, imm_i[1]=32'h40 (static) -> not taken, next pc_o=32'h208; same with FETCH_BHT_EN after two upd_taken_i=1 on 32'h204 -> target 32'h244.
- REQ-031: out_ready_i=0 for 3 cycles with out_valid_o=1 -> packet and pc_o frozen; out_ready_i=1 -> new capture next cycle.
- REQ-032: redirect_i=1, redirect_pc_i=32'h8000, concurrent with stall_i=1 and out_valid_o=1 -> next cycle pc_o=32'h8000, out_valid_o=0, FLUSH one cycle, then capture at 32'h8000.
- REQ-033: rst asserted mid-stream with out_valid_o=1 and redirect_i=1 -> next cycle pc_o=RESET_PC, out_valid_o=0, state BOOT.
